uart_tx: RTL and testbench

8-bit UART transmitter for the serial loopback/test path. It serialises bytes into 8N1 frames (8E1 with parity compiled in) on `tx_uart`, and that line drives the serial receiver input directly. Source logic hands over bytes with a valid/ready handshake. Bit period is set by a cycle-count divider; the default is 9600 baud from a 50 MHz clock.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and parity helper.
// The UART_TX_PARITY_EN macro selects 8E1 framing in both tx and rx.
package uart_pkg;

  localparam int BAUD_DIV_DEF   = 5208;
  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
  localparam int CNT0_W         = 13;
  localparam int CNT1_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic even_par(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte hand-over bundle between a source and the UART transmitter.
// Transfer happens on a rising edge with tx_vld && tx_rdy.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_vld;
  logic                 tx_rdy;

  modport master (
    output tx_data,
    output tx_vld,
    input  tx_rdy
  );

  modport slave (
    input  tx_data,
    input  tx_vld,
    output tx_rdy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled, ticks on the last
// count and wraps; held at zero when disabled.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [CNT0_W-1:0] LAST = CNT0_W'(DIV - 1);

  logic [CNT0_W-1:0] cnt0_q;
  logic [CNT0_W-1:0] cnt0_d;

  assign tick = en && (cnt0_q == LAST);

  always_comb begin
    cnt0_d = '0;
    if (en && !tick) begin
      cnt0_d = cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input; define
// UART_TX_PARITY_EN for 8E1 (even parity bit after the data bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave tx_if,
  output logic     tx_uart
);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

  localparam logic [CNT1_W-1:0] LAST_BIT = CNT1_W'(FRAME_BITS - 1);
  localparam logic [CNT1_W-1:0] LAST_DAT = CNT1_W'(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [CNT1_W-1:0]    cnt1_q, cnt1_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_uart_q, tx_uart_d;
  logic                 busy;
  logic                 accept;
  logic                 end_cnt0;
  logic                 end_cnt1;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  assign busy         = (state_q != IDLE);
  assign tx_if.tx_rdy = !busy;
  assign accept       = tx_if.tx_vld && !busy;
  assign end_cnt1     = end_cnt0 && (cnt1_q == LAST_BIT);
  assign tx_uart      = tx_uart_q;

  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (busy),
    .tick  (end_cnt0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt1_q    <= '0;
      sh_q      <= '0;
      tx_uart_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt1_q    <= cnt1_d;
      sh_q      <= sh_d;
      tx_uart_q <= tx_uart_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = even_par(tx_if.tx_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept)   state_d = START;
      START:  if (end_cnt0) state_d = DATA;
      DATA: begin
        if (end_cnt0 && (cnt1_q == LAST_DAT)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (end_cnt0) state_d = STOP;
      STOP:   if (end_cnt1) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Shift only between data bits so sh_d[0] is always the bit on the line.
  always_comb begin
    cnt1_d = cnt1_q;
    sh_d   = sh_q;
    if (end_cnt1) begin
      cnt1_d = '0;
    end else if (end_cnt0) begin
      cnt1_d = cnt1_q + 1'b1;
    end
    if (accept) begin
      sh_d = tx_if.tx_data;
    end else if ((state_q == DATA) && end_cnt0) begin
      sh_d = sh_q >> 1;
    end
  end

  always_comb begin
    tx_uart_d = 1'b1;
    unique case (state_d)
      IDLE:   tx_uart_d = 1'b1;
      START:  tx_uart_d = 1'b0;
      DATA:   tx_uart_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_uart_d = par_q;
`else
      PARITY: tx_uart_d = 1'b1;
`endif
      STOP:   tx_uart_d = 1'b1;
      default: tx_uart_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (BAUD_DIV 16 and 2),
// frames decoded by a sampling receiver and checked against a scoreboard.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DA = 16;
  localparam int DB = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FB  = FRAME_BITS_8E1;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = FRAME_BITS_8N1;
  localparam bit PAR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic a_uart;
  logic b_uart;

  uart_tx_if a_if ();
  uart_tx_if b_if ();

  uart_tx #(.BAUD_DIV(DA)) u_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_if   (a_if),
    .tx_uart (a_uart)
  );

  uart_tx #(.BAUD_DIV(DB)) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_if   (b_if),
    .tx_uart (b_uart)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic       line_q[$];
  logic       rdy_q[$];
  logic [7:0] sb_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (PAR && i == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic send(input bit sel, input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      b_if.tx_data = d;
      b_if.tx_vld  = 1'b1;
    end else begin
      a_if.tx_data = d;
      a_if.tx_vld  = 1'b1;
    end
    sb_q.push_back(d);
    @(posedge clk);
    #1;
    a_if.tx_vld = 1'b0;
    b_if.tx_vld = 1'b0;
  endtask

  task automatic record(input bit sel, input int n);
    line_q.delete();
    rdy_q.delete();
    repeat (n) begin
      @(negedge clk);
      line_q.push_back(sel ? b_uart : a_uart);
      rdy_q.push_back(sel ? b_if.tx_rdy : a_if.tx_rdy);
    end
  endtask

  task automatic frame_bad(input int div, input int off,
                           input logic [7:0] d, output int bad);
    bad = 0;
    for (int i = 0; i < FB; i++)
      for (int j = 0; j < div; j++)
        if (line_q[off+i*div+j] !== exp_bit(d, i)) bad++;
  endtask

  task automatic decode(input int div, input int off,
                        output logic [7:0] b, output logic p);
    for (int k = 0; k < 8; k++)
      b[k] = line_q[off+(k+1)*div+div/2];
    p = line_q[off+9*div+div/2];
  endtask

  task automatic run_len(input int off, input logic v, output int n);
    n = 0;
    while (off + n < rdy_q.size() && rdy_q[off+n] === v) n++;
  endtask

  task automatic sb_check(input string nm, input logic [7:0] got);
    logic [7:0] e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got %h with scoreboard empty", nm, got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, got, e);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_uart !== 1'b1) begin
      n_fail++; $display("FAIL rst_a_uart: got %b expected 1", a_uart);
    end
    n_chk++;
    if (a_if.tx_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rst_a_rdy: got %b expected 1", a_if.tx_rdy);
    end
    n_chk++;
    if (b_uart !== 1'b1) begin
      n_fail++; $display("FAIL rst_b_uart: got %b expected 1", b_uart);
    end
    a_if.tx_vld = 1'b0; a_if.tx_data = '0;
    b_if.tx_vld = 1'b0; b_if.tx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (a_uart !== 1'b1 || a_if.tx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_idle: got uart=%b rdy=%b expected 1/1",
               a_uart, a_if.tx_rdy);
    end
  endtask

  task automatic test_frame_55();
    int bad, n;
    logic [7:0] b;
    logic p;
    send(1'b0, 8'h55);
    record(1'b0, FB*DA + 8);
    frame_bad(DA, 0, 8'h55, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL f55_bits: got %0d bad cycles expected 0", bad);
    end
    run_len(0, 1'b0, n);
    n_chk++;
    if (n !== FB*DA) begin
      n_fail++; $display("FAIL f55_rdy_low: got %0d expected %0d", n, FB*DA);
    end
    decode(DA, 0, b, p);
    sb_check("f55_decode", b);
  endtask

  task automatic test_back_to_back();
    int bad, n;
    bit got;
    logic [7:0] b;
    logic p;
    @(negedge clk);
    a_if.tx_data = 8'hA5;
    a_if.tx_vld  = 1'b1;
    sb_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    a_if.tx_data = 8'h3C;
    sb_q.push_back(8'h3C);
    got = 1'b0;
    fork
      record(1'b0, 2*FB*DA + 8);
      begin
        for (int c = 0; c < FB*DA + 20; c++) begin
          @(negedge clk);
          if (a_if.tx_rdy) begin
            @(posedge clk);
            #1;
            a_if.tx_vld = 1'b0;
            got = 1'b1;
            break;
          end
        end
        a_if.tx_vld = 1'b0;
      end
    join
    n_chk++;
    if (!got) begin
      n_fail++; $display("FAIL b2b_timeout: got no second accept expected one");
    end
    frame_bad(DA, 0, 8'hA5, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL b2b_f1_bits: got %0d bad expected 0", bad);
    end
    run_len(0, 1'b0, n);
    n_chk++;
    if (n !== FB*DA) begin
      n_fail++; $display("FAIL b2b_f1_rdy: got %0d expected %0d", n, FB*DA);
    end
    run_len(FB*DA, 1'b1, n);
    n_chk++;
    if (n !== 1) begin
      n_fail++; $display("FAIL b2b_rdy_gap: got %0d expected 1", n);
    end
    frame_bad(DA, FB*DA + 1, 8'h3C, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL b2b_f2_bits: got %0d bad expected 0", bad);
    end
    run_len(FB*DA + 1, 1'b0, n);
    n_chk++;
    if (n !== FB*DA) begin
      n_fail++; $display("FAIL b2b_f2_rdy: got %0d expected %0d", n, FB*DA);
    end
    decode(DA, 0, b, p);
    sb_check("b2b_decode1", b);
    decode(DA, FB*DA + 1, b, p);
    sb_check("b2b_decode2", b);
  endtask

  task automatic test_ignore_busy();
    int bad, n;
    logic [7:0] b;
    logic p;
    send(1'b0, 8'h00);
    fork
      record(1'b0, FB*DA + 3*DA);
      begin
        repeat (3*DA) @(negedge clk);
        a_if.tx_data = 8'hFF;
        a_if.tx_vld  = 1'b1;
        @(negedge clk);
        a_if.tx_vld  = 1'b0;
        a_if.tx_data = 8'h00;
      end
    join
    frame_bad(DA, 0, 8'h00, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL ign_bits: got %0d bad expected 0", bad);
    end
    run_len(0, 1'b0, n);
    n_chk++;
    if (n !== FB*DA) begin
      n_fail++; $display("FAIL ign_rdy: got %0d expected %0d", n, FB*DA);
    end
    bad = 0;
    for (int i = FB*DA; i < FB*DA + 3*DA; i++)
      if (line_q[i] !== 1'b1) bad++;
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL ign_no_ff: got %0d low cycles expected 0", bad);
    end
    decode(DA, 0, b, p);
    sb_check("ign_decode", b);
    n_chk++;
    if (sb_q.size() !== 0) begin
      n_fail++; $display("FAIL ign_sb_left: got %0d expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int bad, n;
    logic [7:0] b;
    logic [7:0] dropped;
    logic p;
    send(1'b0, 8'h81);
    record(1'b0, 5*DA + DA/2);
    n_chk++;
    if (line_q[5*DA + DA/2 - 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_bit4: got %b expected 0", line_q[5*DA + DA/2 - 1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_uart !== 1'b1) begin
      n_fail++; $display("FAIL abort_uart: got %b expected 1", a_uart);
    end
    n_chk++;
    if (a_if.tx_rdy !== 1'b1) begin
      n_fail++; $display("FAIL abort_rdy: got %b expected 1", a_if.tx_rdy);
    end
    dropped = sb_q.pop_front();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    record(1'b0, 2*DA);
    bad = 0;
    foreach (line_q[i]) if (line_q[i] !== 1'b1) bad++;
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_no_resume: got %0d low cycles for %h expected 0",
               bad, dropped);
    end
    send(1'b0, 8'h81);
    record(1'b0, FB*DA + 4);
    frame_bad(DA, 0, 8'h81, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_resend: got %0d bad expected 0", bad);
    end
    run_len(0, 1'b0, n);
    n_chk++;
    if (n !== FB*DA) begin
      n_fail++; $display("FAIL abort_rdy_len: got %0d expected %0d", n, FB*DA);
    end
    decode(DA, 0, b, p);
    sb_check("abort_decode", b);
  endtask

  task automatic test_parity();
    logic [7:0] dat[2] = '{8'h07, 8'h03};
    logic       epar[2] = '{1'b1, 1'b0};
    int n, bad;
    logic [7:0] b;
    logic p;
    for (int t = 0; t < 2; t++) begin
      send(1'b0, dat[t]);
      record(1'b0, FB*DA + 4);
      run_len(0, 1'b0, n);
      n_chk++;
      if (n !== FB*DA) begin
        n_fail++;
        $display("FAIL par_len_%0d: got %0d expected %0d", t, n, FB*DA);
      end
      frame_bad(DA, 0, dat[t], bad);
      n_chk++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL par_bits_%0d: got %0d bad expected 0", t, bad);
      end
      decode(DA, 0, b, p);
      n_chk++;
      if (p !== (PAR ? epar[t] : 1'b1)) begin
        n_fail++;
        $display("FAIL par_bit_%0d: got %b expected %b",
                 t, p, PAR ? epar[t] : 1'b1);
      end
      sb_check("par_decode", b);
    end
  endtask

  task automatic test_div2();
    int bad, n;
    logic [7:0] b;
    logic p;
    send(1'b1, 8'hC3);
    record(1'b1, FB*DB + 4);
    frame_bad(DB, 0, 8'hC3, bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL div2_bits: got %0d bad expected 0", bad);
    end
    run_len(0, 1'b0, n);
    n_chk++;
    if (n !== FB*DB) begin
      n_fail++; $display("FAIL div2_len: got %0d expected %0d", n, FB*DB);
    end
    decode(DB, 0, b, p);
    sb_check("div2_decode", b);
  endtask

  initial begin
    test_reset();
    test_frame_55();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_parity();
    test_div2();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
